// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/control logic.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 2;

    // Interrupt entry sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SAVE   = 2'b01,
        MASKED = 2'b10
    } state_e;

    // Next-PC source encodings
    localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;
    localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
    localparam logic [SEL_W-1:0] PC_VEC = 2'b10;

endpackage

// File: rtl/stall_timer.sv
// Saturating memory-wait length counter with a sticky timeout flag.
module stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_wt,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Count consecutive wait cycles; flag fires when the last allowed cycle is still waiting
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q;
        if (mem_wt) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_HIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush driver: load-use, back-end stalls, mispredicts, interrupt entry.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_p0_addr,
    input  logic [REG_AW-1:0] id_p1_addr,
    input  logic              id_p0_used,
    input  logic              id_p1_used,
    input  logic              ex_mem_re,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic              ex_mispredict,
    input  logic              mem_wt,
    input  logic              accel_busy,
    input  logic              ex_send,
    input  logic              spart_full,
    input  logic              intr_req,
    input  logic              intr_ret,
    output logic              pc_stall,
    output logic [SEL_W-1:0]  pc_sel,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              id_ex_store_current,
    output logic              ex_mem_stall,
    output logic              intr_ack,
    output logic              mem_timeout
);

    state_e state_q, state_d;
    logic   pend_q, pend_d;
    logic   intr_ack_q, intr_ack_d;
    logic   back_stall;
    logic   load_use;
    logic   timeout_raw;

    // Hazard detection
    assign back_stall = mem_wt | accel_busy | (ex_send & spart_full);
    assign load_use   = ex_mem_re & ex_we &
                        ((id_p0_used & (id_p0_addr == ex_dst_addr)) |
                         (id_p1_used & (id_p1_addr == ex_dst_addr)));

    // State, pending-interrupt and ack registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pend_q     <= 1'b0;
            intr_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            intr_ack_q <= intr_ack_d;
        end
    end

    // Next-state: enter SAVE only on a hazard-free cycle; SAVE completes when nothing outranks it
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        intr_ack_d = 1'b0;
        case (state_q)
            RUN: begin
                if (intr_req) begin
                    pend_d = 1'b1;
                end
                if (pend_q && !back_stall && !ex_mispredict && !load_use) begin
                    state_d = SAVE;
                end
            end
            SAVE: begin
                if (!back_stall && !ex_mispredict) begin
                    state_d    = MASKED;
                    pend_d     = 1'b0;
                    intr_ack_d = 1'b1;
                end
            end
            MASKED: begin
                if (intr_ret && !back_stall) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs: fixed priority back_stall > mispredict > SAVE > load_use, all quiet in reset
    always_comb begin
        pc_stall            = 1'b0;
        pc_sel              = PC_SEQ;
        if_id_stall         = 1'b0;
        if_id_flush         = 1'b0;
        id_ex_stall         = 1'b0;
        id_ex_flush         = 1'b0;
        id_ex_store_current = 1'b0;
        ex_mem_stall        = 1'b0;
        if (!rst) begin
            if (back_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (ex_mispredict) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                pc_sel      = PC_BR;
            end else if (state_q == SAVE) begin
                id_ex_store_current = 1'b1;
                if_id_flush         = 1'b1;
                pc_sel              = PC_VEC;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    stall_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_stall_timer (
        .clk         (clk),
        .rst         (rst),
        .mem_wt      (mem_wt),
        .mem_timeout (timeout_raw)
    );

    assign intr_ack    = intr_ack_q & ~rst;
    assign mem_timeout = timeout_raw & ~rst;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the 16-bit core: the driver side of the stall/flush/store_current controls consumed by the IF_ID, ID_EX and EX_MEM pipeline registers and the PC register. It detects load-use hazards, back-end stalls (memory wait, accelerator, full SPART on send) and EX-stage branch mispredicts. It sequences interrupt entry through a small state machine and watches memory-wait length with a timeout counter.

## Interface
- `WAIT_LIMIT`, 255: consecutive `mem_wt` cycles that set `mem_timeout`; legal range 1..255.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_p0_addr`, `id_p1_addr` in 4 each: source register addresses in ID.
- `id_p0_used`, `id_p1_used` in 1 each: the ID instruction reads that source.
- `ex_mem_re` in 1: the EX instruction is a load.
- `ex_we` in 1: the EX instruction writes a register.
- `ex_dst_addr` in 4: EX destination register.
- `ex_mispredict` in 1: EX branch resolved opposite to its prediction.
- `mem_wt` in 1: data memory not ready.
- `accel_busy` in 1: accelerator busy.
- `ex_send` in 1: the EX instruction sends to the SPART.
- `spart_full` in 1: SPART transmit buffer full.
- `intr_req` in 1: level interrupt request.
- `intr_ret` in 1: return-from-interrupt in EX.
- `pc_stall` out 1: hold the PC.
- `pc_sel` out 2: next-PC source; 00 = sequential/predicted, 01 = corrected branch, 10 = interrupt vector.
- `if_id_stall`, `if_id_flush` out 1 each: IF_ID controls.
- `id_ex_stall`, `id_ex_flush`, `id_ex_store_current` out 1 each: ID_EX controls.
- `ex_mem_stall` out 1: EX_MEM control.
- `intr_ack` out 1: one-cycle pulse when interrupt entry completes.
- `mem_timeout` out 1: sticky; set by a memory-wait timeout.

## Operation
- `back_stall` = `mem_wt` | `accel_busy` | (`ex_send` & `spart_full`).
- `load_use` = `ex_mem_re` & `ex_we` & ((`id_p0_used` & `id_p0_addr`==`ex_dst_addr`) | (`id_p1_used` & `id_p1_addr`==`ex_dst_addr`)).
- Priority, highest first: rst, back_stall, ex_mispredict, interrupt entry, load_use.
- **back_stall:** assert `pc_stall`, `if_id_stall`, `id_ex_stall` and `ex_mem_stall`. Drive all flush outputs 0, `store_current` 0 and `pc_sel`=00.
- **ex_mispredict (no back_stall):** assert `if_id_flush` and `id_ex_flush`, with `pc_sel`=01. No stalls.
- **load_use (nothing higher):** assert `pc_stall`, `if_id_stall` and `id_ex_flush` (bubble).
- **FSM states:** RUN, SAVE, MASKED.
- **`pend` register:** set by `intr_req` when the FSM is in RUN; cleared on leaving SAVE.
- **RUN -> SAVE:** when `pend` is set and no back_stall, ex_mispredict or load_use is present this cycle.
- **SAVE cycle:**
  - If back_stall: back_stall outputs only; stay in SAVE.
  - Else if ex_mispredict: mispredict outputs; stay in SAVE.
  - Otherwise: `id_ex_store_current`=1, `if_id_flush`=1, `pc_sel`=10, then go to MASKED with `intr_ack`=1 the next cycle.
- **MASKED:** `intr_req` is ignored. Go to RUN on `intr_ret` & ~back_stall.
- **Timeout counter (8 bits):**
  - Increments each cycle `mem_wt`=1, saturating at 255.
  - Clears when `mem_wt`=0.
  - When the count reaches `WAIT_LIMIT`-1 with `mem_wt` still high, `mem_timeout` sets the next edge and stays set until `rst`.

## Timing
- All stall/flush/`pc_sel`/`store_current` outputs are combinational from the inputs and registered state. They are valid in the same cycle and sampled by the pipe registers at the next edge.
- `intr_ack` is registered: exactly one cycle high, the cycle after the completing SAVE cycle.
- **Reset:**
  - FSM in RUN, with `pend`, the counter, `intr_ack` and `mem_timeout` at 0.
  - While `rst`=1, every output is 0 and `pc_sel`=00.
  - A reset during SAVE or MASKED abandons the interrupt; no ack is produced.
- Interrupt latency from `intr_req` in RUN with no hazards: `pend` is set at edge 1, SAVE is active in cycle 2, and `intr_ack` goes high in cycle 3.
- `intr_req` and `ex_mispredict` in the same cycle: mispredict outputs that cycle, and `pend` is still captured.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the FSM state enum (RUN, SAVE, MASKED);
  - the `pc_sel` encodings PC_SEQ=00, PC_BR=01, PC_VEC=10.
- One sub-module, `stall_timer`: the saturating wait counter and sticky timeout flag, parameterised by `WAIT_LIMIT`.

## Test plan
- **Load-use:** `ex_mem_re`=1, `ex_we`=1, `ex_dst_addr`=3, `id_p1_addr`=3, `id_p1_used`=1 -> `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1 for that cycle only. With `ex_dst_addr`=4 -> all outputs 0.
- **Mispredict under memory wait:** `mem_wt`=1 and `ex_mispredict`=1 -> four stalls and no flush. With `mem_wt`=0 the next cycle -> `if_id_flush`=`id_ex_flush`=1 and `pc_sel`=01.
- **Interrupt entry:** `intr_req` pulse in RUN -> SAVE two cycles later with `store_current`=1 and `pc_sel`=10, then `intr_ack` for one cycle. A second `intr_req` in MASKED is ignored until `intr_ret`.
- **Stall inside SAVE:** `accel_busy`=1 for 3 cycles while in SAVE -> `store_current` stays 0 for those 3 cycles and is asserted on cycle 4.
- **Timeout:** with `WAIT_LIMIT`=4 and `mem_wt` high for 4 cycles -> `mem_timeout`=1 after the 4th edge. It stays 1 after `mem_wt` drops and clears only on `rst`.
- **SPART send:** `ex_send`=1 and `spart_full`=1 -> all stalls asserted. With `spart_full`=0 -> stalls released the same cycle.
